// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the register file and its pending-write scoreboard:
//   - default register width / index width
//   - XZR index for the default index width
//   - zero_reg_index(): XZR index for any index width
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    // The zero register is always the highest index of the bank.
    function automatic int zero_reg_index(input int addr_width);
        return (1 << addr_width) - 1;
    endfunction

    localparam logic [DEFAULT_ADDR_WIDTH-1:0] XZR_INDEX =
        DEFAULT_ADDR_WIDTH'(zero_reg_index(DEFAULT_ADDR_WIDTH));

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Per-register busy tracking for read-after-write hazard detection.
// Ports:
//   clock, reset_n        clock / asynchronous active-low reset
//   rsv_en, rsv_addr      decode reserves a destination register
//   wr_en, wr_addr        writeback completes a register
//   flush                 pipeline squash, clears every busy bit
//   busy                  one busy bit per register
//   busy_count            registered popcount of busy
// Priority per index: flush > reserve > write > hold.
// ---------------------------------------------------------------------------
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         rsv_en,
    input  logic [ADDR_WIDTH-1:0]        rsv_addr,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic                         flush,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy,
    output logic [ADDR_WIDTH:0]          busy_count
);

    localparam int                    DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZR_IDX = ADDR_WIDTH'(zero_reg_index(ADDR_WIDTH));
    localparam bit                    ZR_EN  = (ZERO_REG != 0);

    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_WIDTH:0] count_next;

    // NOTE: every variable written in always_comb gets a default first so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        busy_next = busy;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush) begin
                busy_next[k] = 1'b0;
            end else if (rsv_en && rsv_addr == ADDR_WIDTH'(k)
                         && !(ZR_EN && ADDR_WIDTH'(k) == ZR_IDX)) begin
                // A new producer wins over a write completing the old one.
                busy_next[k] = 1'b1;
            end else if (wr_en && wr_addr == ADDR_WIDTH'(k)) begin
                busy_next[k] = 1'b0;
            end
        end
    end

    // Count is taken from the next state so it lands on the same edge.
    always_comb begin
        count_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_next = count_next + {{ADDR_WIDTH{1'b0}}, busy_next[k]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
// Multi-read-port register file with XZR, write-to-read bypass and a
// pending-write scoreboard.
// Ports:
//   clock, reset_n        clock / asynchronous active-low reset
//   rd_addr, rd_data      packed per-port read index / combinational data
//   rd_busy               per-port: addressed register has a reservation
//   wr_en/addr/data       writeback
//   rsv_en, rsv_addr      decode reservation
//   flush                 clears all busy bits
//   busy_count            registered count of busy registers
// ---------------------------------------------------------------------------
module register_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int READ_PORTS = 3,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_busy,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rsv_en,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr,
    input  logic                             flush,
    output logic [ADDR_WIDTH:0]              busy_count
);

    localparam int                    DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZR_IDX = ADDR_WIDTH'(zero_reg_index(ADDR_WIDTH));
    localparam bit                    ZR_EN  = (ZERO_REG != 0);
    localparam bit                    BYP_EN = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  write_blocked;

    assign write_blocked = ZR_EN && (wr_addr == ZR_IDX);

    // NOTE: the storage array is reset on purpose: the bank must read as all
    // zeros while reset_n is low, so each entry carries an async clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_en && !write_blocked) begin
            regs[wr_addr] <= wr_data;
        end
    end

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clock      (clock),
        .reset_n    (reset_n),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .busy       (busy),
        .busy_count (busy_count)
    );

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  busy_bit;

        assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // XZR beats bypass, bypass beats storage. Reset forces zeros so a
        // write strobe held during reset cannot leak through the bypass.
        always_comb begin
            data     = '0;
            busy_bit = 1'b0;
            if (!reset_n || (ZR_EN && addr == ZR_IDX)) begin
                data     = '0;
                busy_bit = 1'b0;
            end else if (BYP_EN && wr_en && wr_addr == addr) begin
                data     = wr_data;
                busy_bit = 1'b0;
            end else begin
                data     = regs[addr];
                busy_bit = busy[addr];
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_busy[p]                          = busy_bit;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_register_file_mp
// Two instances share all inputs: dut (BYPASS=1) and dut_nb (BYPASS=0).
// A behavioural model (register array + busy set) predicts both.
// ---------------------------------------------------------------------------
module tb_register_file_mp;
    import reg_file_pkg::*;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int NP    = 3;
    localparam int DEPTH = 32;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data, rd_data_nb;
    logic [NP-1:0]    rd_busy, rd_busy_nb;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            flush;
    logic [AW:0]     busy_count, busy_count_nb;

    always #5 clock = ~clock;

    register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(NP),
                       .ZERO_REG(1), .BYPASS(1)) dut (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_count(busy_count)
    );

    register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(NP),
                       .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_count(busy_count_nb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    // Applied at each rising edge with the inputs that were present.
    task automatic model_step();
        if (wr_en && wr_addr != XZR_INDEX) m_regs[wr_addr] = wr_data;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) m_busy[k] = 1'b0;
        end else begin
            if (wr_en) m_busy[wr_addr] = 1'b0;
            if (rsv_en && rsv_addr != XZR_INDEX) m_busy[rsv_addr] = 1'b1;
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int k = 0; k < DEPTH; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    function automatic logic [DW-1:0] exp_data(input int p, input bit byp);
        logic [AW-1:0] a = rd_addr[p*AW +: AW];
        if (a == XZR_INDEX) return '0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int p, input bit byp);
        logic [AW-1:0] a = rd_addr[p*AW +: AW];
        if (a == XZR_INDEX) return 1'b0;
        if (byp && wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check_all(input string tag);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("%s data%0d", tag, p), rd_data[p*DW +: DW], exp_data(p, 1'b1));
            check($sformatf("%s busy%0d", tag, p), 64'(rd_busy[p]), 64'(exp_busy(p, 1'b1)));
            check($sformatf("%s nb_data%0d", tag, p), rd_data_nb[p*DW +: DW], exp_data(p, 1'b0));
            check($sformatf("%s nb_busy%0d", tag, p), 64'(rd_busy_nb[p]), 64'(exp_busy(p, 1'b0)));
        end
        check({tag, " count"}, 64'(busy_count), 64'(model_count()));
        check({tag, " nb_count"}, 64'(busy_count_nb), 64'(model_count()));
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rsv_en = 0; rsv_addr = '0; flush = 0;
    endtask

    // Inputs already driven; check mid-cycle, then clock and update model.
    task automatic cycle_checked(input string tag);
        @(negedge clock);
        check_all(tag);
        @(posedge clock);
        model_step();
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rsv_en;
        logic [AW-1:0] rsv_addr;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          flush;
        logic [AW-1:0] rd0;
        logic [DW-1:0] exp_data;   // rd_data port0 in the same cycle (bypass)
        logic          exp_busy;   // rd_busy port0 in the same cycle
        int            exp_count;  // busy_count after the edge
    } vec_t;

    vec_t vecs [11];

    initial begin
        //           rsv   rsva  wr    wra    wdata        fl    rd0    exp_d        exp_b cnt
        vecs[0]  = '{1'b1, 5'd3, 1'b0, 5'd0,  64'h0,       1'b0, 5'd3,  64'h0,       1'b0, 1};
        vecs[1]  = '{1'b1, 5'd7, 1'b0, 5'd0,  64'h0,       1'b0, 5'd3,  64'h0,       1'b1, 2};
        vecs[2]  = '{1'b0, 5'd0, 1'b1, 5'd3,  64'h33,      1'b0, 5'd3,  64'h33,      1'b0, 1};
        vecs[3]  = '{1'b1, 5'd7, 1'b0, 5'd0,  64'h0,       1'b0, 5'd7,  64'h0,       1'b1, 1};
        vecs[4]  = '{1'b0, 5'd0, 1'b1, 5'd12, 64'hC,       1'b0, 5'd12, 64'hC,       1'b0, 1};
        vecs[5]  = '{1'b1, 5'd9, 1'b1, 5'd9,  64'h99,      1'b0, 5'd9,  64'h99,      1'b0, 2};
        vecs[6]  = '{1'b0, 5'd0, 1'b0, 5'd0,  64'h0,       1'b0, 5'd9,  64'h99,      1'b1, 2};
        vecs[7]  = '{1'b1, 5'd4, 1'b1, 5'd4,  64'h44,      1'b1, 5'd4,  64'h44,      1'b0, 0};
        vecs[8]  = '{1'b0, 5'd0, 1'b0, 5'd0,  64'h0,       1'b0, 5'd4,  64'h44,      1'b0, 0};
        vecs[9]  = '{1'b1, 5'd31, 1'b1, 5'd31, 64'h1234,   1'b0, 5'd31, 64'h0,       1'b0, 0};
        vecs[10] = '{1'b0, 5'd0, 1'b0, 5'd0,  64'h0,       1'b0, 5'd31, 64'h0,       1'b0, 0};

        // ---- reset state ----
        idle();
        rd_addr = {5'd2, 5'd1, 5'd0};
        reset_n = 1'b0;
        model_reset();
        #3;
        check("reset data0", rd_data[63:0], 64'h0);
        check("reset count", 64'(busy_count), 64'h0);
        check("reset busy", 64'(rd_busy), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // ---- table ----
        for (int i = 0; i < 11; i++) begin
            rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            flush = vecs[i].flush;
            rd_addr = {10'd0, vecs[i].rd0};
            @(negedge clock);
            check($sformatf("vec%0d data0", i), rd_data[63:0], vecs[i].exp_data);
            check($sformatf("vec%0d busy0", i), 64'(rd_busy[0]), 64'(vecs[i].exp_busy));
            @(posedge clock);
            model_step();
            #1;
            check($sformatf("vec%0d count", i), 64'(busy_count), 64'(vecs[i].exp_count));
        end
        idle();

        // ---- bypass vs no-bypass on X5 ----
        wr_en = 1; wr_addr = 5'd5; wr_data = 64'h1111;
        rd_addr = {10'd0, 5'd5};
        cycle_checked("byp_pre");
        wr_data = 64'hDEAD_BEEF_0000_0001;
        @(negedge clock);
        check("byp same-cycle", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
        check("nobyp same-cycle", rd_data_nb[63:0], 64'h1111);
        @(posedge clock);
        model_step();
        #1;
        idle();
        check("nobyp next-cycle", rd_data_nb[63:0], 64'hDEAD_BEEF_0000_0001);

        // ---- three ports reading X2 while it is written (X2 reserved first) ----
        rsv_en = 1; rsv_addr = 5'd2;
        rd_addr = {5'd2, 5'd2, 5'd2};
        cycle_checked("x2_rsv");
        idle();
        wr_en = 1; wr_addr = 5'd2; wr_data = 64'hA5A5_5A5A_0F0F_F0F0;
        @(negedge clock);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("x2 data%0d", p), rd_data[p*DW +: DW], 64'hA5A5_5A5A_0F0F_F0F0);
            check($sformatf("x2 busy%0d", p), 64'(rd_busy[p]), 64'h0);
        end
        check("x2 nb busy0", 64'(rd_busy_nb[0]), 64'h1);
        @(posedge clock);
        model_step();
        #1;
        idle();

        // ---- randomized against the model ----
        for (int n = 0; n < 400; n++) begin
            rd_addr  = NP*AW'($urandom);
            wr_en    = 1'($urandom);
            wr_addr  = AW'($urandom);
            wr_data  = {$urandom, $urandom};
            rsv_en   = 1'($urandom);
            rsv_addr = AW'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            cycle_checked($sformatf("rnd%0d", n));
        end
        idle();

        // ---- fill 0..30, reserve a few, then async reset mid-cycle ----
        for (int k = 0; k < 31; k++) begin
            wr_en = 1; wr_addr = AW'(k); wr_data = {32'hF00D_0000, 32'(k + 1)};
            rsv_en = (k % 4 == 0); rsv_addr = AW'(k + 1);
            @(posedge clock);
            model_step();
            #1;
        end
        idle();
        rd_addr = {5'd30, 5'd15, 5'd0};
        @(negedge clock);
        check_all("pre_reset");
        @(posedge clock);
        model_step();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int p = 0; p < NP; p++) begin
            check($sformatf("midreset data%0d", p), rd_data[p*DW +: DW], 64'h0);
            check($sformatf("midreset nb_data%0d", p), rd_data_nb[p*DW +: DW], 64'h0);
        end
        check("midreset busy", 64'(rd_busy), 64'h0);
        check("midreset count", 64'(busy_count), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        rsv_en = 1; rsv_addr = 5'd15;
        cycle_checked("cold0");
        idle();
        cycle_checked("cold1");
        check("cold count", 64'(busy_count), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
